// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the four-way round-robin arbiter.
package rr_arb_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned IDX_W = 2;

  typedef enum logic [0:0] {
    StIdle,
    StGrant
  } state_e;

endpackage

// File: rtl/rr_arb4_dec.sv
// Combinational 2-to-4 one-hot decoder with enable; all-zero output when disabled.
module onehot_dec2x4
  import rr_arb_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  input  logic             en,
  output logic [N_REQ-1:0] y
);

  always_comb begin
    y = '0;
    if (en) begin
      unique case (idx)
        2'd0: y = 4'b0001;
        2'd1: y = 4'b0010;
        2'd2: y = 4'b0100;
        2'd3: y = 4'b1000;
        default: y = '0;
      endcase
    end
  end

endmodule

// File: rtl/rr_arb4.sv
// Four-requester round-robin arbiter with held, registered one-hot grants.
// Optional hold timeout compiled in with `define RR_ARB_TIMEOUT_EN.
module rr_arb4
  import rr_arb_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld,
  output logic             tmo
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic             gnt_vld_q, gnt_vld_d;
  logic             tmo_q, tmo_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             timeout;

  // First set request at or after the rotation pointer, wrapping mod 4.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                               input logic [IDX_W-1:0] p);
    logic [IDX_W-1:0] idx;
    logic             found;
    rr_pick = p;
    found   = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = p + IDX_W'(i);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

`ifdef RR_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(HOLD_MAX + 1);

  logic [CntW-1:0] hold_q, hold_d;

  assign timeout = (state_q == StGrant) && (hold_q == CntW'(HOLD_MAX));

  // Loaded with 1 while idle so the first granted cycle counts as 1.
  always_comb begin
    hold_d = hold_q;
    if (state_q == StIdle) begin
      hold_d = CntW'(1);
    end else if (!timeout) begin
      hold_d = hold_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
    end else begin
      hold_q <= hold_d;
    end
  end
`else
  logic unused_hold_max;
  assign unused_hold_max = ^8'(HOLD_MAX);
  assign timeout         = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_idx_d = gnt_idx_q;
    gnt_vld_d = 1'b0;
    tmo_d     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (en && (req != '0)) begin
          gnt_idx_d = rr_pick(req, ptr_q);
          ptr_d     = gnt_idx_d + IDX_W'(1);
          gnt_vld_d = 1'b1;
          state_d   = StGrant;
        end
      end
      StGrant: begin
        if (en && req[gnt_idx_q]) begin
          if (timeout) begin
            tmo_d   = 1'b1;
            state_d = StIdle;
          end else begin
            gnt_vld_d = 1'b1;
          end
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  onehot_dec2x4 u_dec (
    .idx (gnt_idx_d),
    .en  (gnt_vld_d),
    .y   (gnt_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      gnt_idx_q <= '0;
      gnt_vld_q <= 1'b0;
      tmo_q     <= 1'b0;
      gnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_idx_q <= gnt_idx_d;
      gnt_vld_q <= gnt_vld_d;
      tmo_q     <= tmo_d;
      gnt_q     <= gnt_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = gnt_idx_q;
  assign gnt_vld = gnt_vld_q;
  assign tmo     = tmo_q;

endmodule

// File: tb/tb_rr_arb4.sv
// Self-checking bench for rr_arb4: directed steps, then random traffic against a reference model.
module tb_rr_arb4;

  localparam int unsigned HoldMax = 3;
`ifdef RR_ARB_TIMEOUT_EN
  localparam bit TmoEn = 1'b1;
`else
  localparam bit TmoEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_vld;
  logic       tmo;

  int total = 0;
  int bad = 0;

  // Reference model state
  bit m_busy = 0;
  int m_idx = 0;
  int m_ptr = 0;
  int m_hold = 0;
  bit m_tmo = 0;

  rr_arb4 #(.HOLD_MAX(HoldMax)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .req     (req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .tmo     (tmo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input logic [3:0] r, input logic e, input logic rs);
    m_tmo = 0;
    if (rs) begin
      m_busy = 0; m_idx = 0; m_ptr = 0; m_hold = 0;
    end else if (!m_busy) begin
      if (e && r != 4'b0000) begin
        for (int k = 0; k < 4; k++) begin
          if (!m_busy && r[(m_ptr + k) % 4]) begin
            m_idx  = (m_ptr + k) % 4;
            m_busy = 1;
          end
        end
        m_ptr  = (m_idx + 1) % 4;
        m_hold = 1;
      end
    end else if (e && r[m_idx]) begin
      if (TmoEn && m_hold == int'(HoldMax)) begin
        m_busy = 0;
        m_tmo  = 1;
      end else begin
        m_hold++;
      end
    end else begin
      m_busy = 0;
    end
  endtask

  // Drive one cycle of inputs, advance model at the edge, compare just after it.
  task automatic step(input logic [3:0] r, input logic e, input logic rs);
    logic [3:0] exp_gnt;
    req = r; en = e; rst = rs;
    @(posedge clk);
    model_edge(r, e, rs);
    #1;
    exp_gnt = m_busy ? (4'b0001 << m_idx) : 4'b0000;
    chk("gnt", gnt, exp_gnt);
    chk("gnt_idx", {2'b00, gnt_idx}, 4'(m_idx));
    chk("gnt_vld", {3'b000, gnt_vld}, {3'b000, m_busy});
    chk("tmo", {3'b000, tmo}, {3'b000, m_tmo});
  endtask

  initial begin
    logic [3:0] rq;
    logic       e;
    logic       rs;

    // Reset held with everything requesting
    step(4'b1111, 1'b1, 1'b1);
    step(4'b1111, 1'b1, 1'b1);
    chk("reset_gnt", gnt, 4'b0000);
    step(4'b1111, 1'b1, 1'b0);
    chk("first_after_reset", gnt, 4'b0001);

    // Fair rotation: holder drops for one cycle after each grant
    step(4'b1110, 1'b1, 1'b0);
    step(4'b1111, 1'b1, 1'b0);
    chk("rot1", gnt, 4'b0010);
    step(4'b1101, 1'b1, 1'b0);
    step(4'b1111, 1'b1, 1'b0);
    chk("rot2", gnt, 4'b0100);
    step(4'b1011, 1'b1, 1'b0);
    step(4'b1111, 1'b1, 1'b0);
    chk("rot3", gnt, 4'b1000);
    step(4'b0111, 1'b1, 1'b0);
    step(4'b1111, 1'b1, 1'b0);
    chk("rot4", gnt, 4'b0001);
    step(4'b0000, 1'b1, 1'b0);

    // Wrap and skip after index 3
    step(4'b1000, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);
    step(4'b0101, 1'b1, 1'b0);
    chk("wrap0", gnt, 4'b0001);
    step(4'b0100, 1'b1, 1'b0);
    step(4'b0100, 1'b1, 1'b0);
    chk("skip2", gnt, 4'b0100);
    step(4'b0000, 1'b1, 1'b0);

    // Single client held for five cycles
    for (int i = 0; i < 5; i++) step(4'b0100, 1'b1, 1'b0);
    chk("single_idx", {2'b00, gnt_idx}, 4'd2);
    step(4'b0000, 1'b1, 1'b0);
    chk("single_rel", gnt, 4'b0000);

    // Enable gating
    step(4'b0011, 1'b0, 1'b0);
    step(4'b0011, 1'b0, 1'b0);
    chk("en_off", gnt, 4'b0000);
    step(4'b0011, 1'b1, 1'b0);
    chk("en_on", gnt, 4'b0001);
    step(4'b0011, 1'b0, 1'b0);
    chk("en_drop", gnt, 4'b0000);

    // Long hold: timeout cycles when compiled in, otherwise held throughout
    for (int i = 0; i < 25; i++) step(4'b0010, 1'b1, 1'b0);
    step(4'b0000, 1'b1, 1'b0);

    // Reset mid-grant
    step(4'b0100, 1'b1, 1'b0);
    step(4'b0100, 1'b1, 1'b1);
    chk("mid_reset", gnt, 4'b0000);

    // Random traffic; requests toggle occasionally so grants get held
    rq = 4'b0000;
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(3) == 0) rq[b] = ~rq[b];
      end
      e  = ($urandom_range(9) != 0);
      rs = ($urandom_range(99) == 0);
      step(rq, e, rs);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_arb4.md
# rr_arb4

Four-requester round-robin arbiter that shares one resource among four clients and drives a one-hot grant bus. The granted client index is turned into the one-hot grant by an internal 2-to-4 decoder with enable; the enable is the grant-valid. The block sits between the client request lines and the shared resource select. It replaces ad-hoc fixed-priority selects with fair, held grants.

## Interface
Parameters:
- HOLD_MAX, 8, maximum consecutive cycles one grant may be held when the timeout is compiled in; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  arbiter enable; 0 blocks new grants and revokes the current grant.
- req  input  4  request per client, level-sensitive; a client holds req high for as long as it wants the resource.
- gnt  output  4  one-hot grant, all-zero when no grant.
- gnt_idx  output  2  index of the current or last granted client.
- gnt_vld  output  1  1 while a grant is active; gnt equals decode(gnt_idx) when 1, else 4'b0000.
- tmo  output  1  one-cycle pulse when a grant is revoked by timeout.

## Operation
- FSM states: IDLE and GRANT. All outputs are registered.
- Reset values: state=IDLE, gnt=4'b0000, gnt_idx=2'b00, gnt_vld=0, tmo=0, rotation pointer ptr=2'b00, hold counter=0.
- IDLE:
  - If en=1 and req≠0, select the first set req bit scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - Load gnt_idx with the selected index, set ptr <= selected+1 (2-bit wrap, so 3 → 0), and go to GRANT.
  - Otherwise stay in IDLE.
- GRANT:
  - Stay while en=1 and req[gnt_idx]=1 and the timeout has not fired.
  - Go to IDLE when req[gnt_idx]=0, when en=0, or on timeout.
- A requester that drops req and re-raises it competes again from IDLE. There is no priority carry-over beyond ptr.
- Requests from other clients during GRANT are ignored until the return to IDLE. They are not latched.
- Changes to req[gnt_idx]=0 and en=0 in the same cycle are treated as one release.
- gnt_idx keeps its last value in IDLE. Only gnt_vld and gnt clear.

## Timing
- Grant latency is 1 cycle: req sampled high at edge N puts gnt/gnt_vld high after edge N.
- Release latency is 1 cycle: req[gnt_idx] sampled low at edge N puts gnt low after edge N.
- There is a mandatory one-cycle IDLE bubble between any two grants, including a re-grant to the same client.
- Back-to-back service of all four persistent requesters therefore takes 2 cycles per grant, minimum.
- rst=1 at any edge, including mid-GRANT, forces all reset values after that edge, regardless of en/req. The first grant after reset goes to the lowest-index requester.
- en=0 in IDLE: no grant issued. The ptr value does not change.

## Configuration
- RR_ARB_TIMEOUT_EN defined:
  - The hold counter is reset to 1 on entry to GRANT and increments each cycle the FSM stays in GRANT.
  - When the counter equals HOLD_MAX and the hold conditions are still true, the FSM goes to IDLE and tmo pulses high for exactly 1 cycle, aligned with gnt going low.
  - With HOLD_MAX=1, every grant lasts exactly 1 cycle.
  - The counter width is $clog2(HOLD_MAX+1).
- RR_ARB_TIMEOUT_EN undefined:
  - No counter is built.
  - tmo is tied to 0 and the port list is unchanged.
  - A grant is held indefinitely while req[gnt_idx]=1 and en=1.

## Structure
- The shared package rr_arb_pkg holds:
  - the state enum (IDLE, GRANT);
  - the constant N_REQ=4;
  - the index width localparam IDX_W=2.
- Sub-module onehot_dec2x4: a combinational 2-to-4 one-hot decoder with enable.
  - Input idx[1:0] and en; output y[3:0], all-zero when en=0.
  - Instantiated with idx=gnt_idx_next and en=gnt_vld_next, and its output is registered into gnt.
- The round-robin priority scan is a function inside rr_arb4.

## Test plan
- Reset: hold rst=1 for 2 cycles with req=4'b1111 and en=1 → gnt=0000, gnt_vld=0, gnt_idx=00, tmo=0. First edge after release → gnt=0001.
- Single client: req=0100 for 5 cycles then 0000 → gnt=0100 from cycle 1 to cycle 5, gnt_idx=10, and gnt=0000 one cycle after req drops.
- Fair rotation: req=1111 held, each holder drops its req for one cycle after each grant → grant order 0001, 0010, 0100, 1000, 0001, with an IDLE bubble between each.
- Wrap and skip: after a grant to index 3, req=0101 → next grant 0001 (index 0), then 0100 (index 2).
- Enable: en=0 with req=0011 → no grant. Raise en=1 → gnt=0001 next cycle. Drop en mid-grant → gnt=0000 next cycle.
- Timeout (RR_ARB_TIMEOUT_EN, HOLD_MAX=3): req=0010 held high → gnt high for exactly 3 cycles, tmo=1 together with gnt low, 1 bubble cycle, then re-grant 0010. Without the macro, gnt stays 0010 for 20+ cycles and tmo stays 0.
